fma_issue_ctrl: RTL and testbench
=================================

FMA_ISSUE_CTRL -- requirements
Module: fma_issue_ctrl

Interface
REQ-001 Parameter LATENCY, default 5: cycles from the fma_a/b/c register update edge to the edge on which fma_result holds the matching result (5-stage clocked FMA).
REQ-002 Parameter DEPTH, default 8: result FIFO entries and total credit; SHALL be >= LATENCY+1 and a power of two.
REQ-003 clk  in  1  clock, rising edge; reset rst, asynchronous, active-high; clock clk.
REQ-004 rst  in  1  asynchronous active-high reset.
REQ-005 in_valid  in  1  operand triple offered.
REQ-006 in_ready  out  1  triple accepted when in_valid&in_ready at a rising edge.
REQ-007 in_a, in_b, in_c  in  32 each  IEEE-754 binary32 operands, result = a*b+c.
REQ-008 fma_a, fma_b, fma_c  out  32 each  registered operands driven to the FMA pipeline.
REQ-009 fma_result  in  32  FMA pipeline result register output.
REQ-010 out_valid  out  1  result available.
REQ-011 out_ready  in  1  consumer takes result when out_valid&out_ready at a rising edge.
REQ-012 out_data  out  32  result, valid while out_valid.
REQ-013 busy  out  1  high when any result is in flight or buffered.

Function
REQ-014 Occupancy occ = in-flight count + FIFO count; occ SHALL be a registered counter, width log2(DEPTH)+1.
REQ-015 in_ready SHALL equal (occ < DEPTH) from registered state only; a same-cycle pop SHALL NOT raise in_ready.
REQ-016 On accept at edge T: fma_a/b/c load in_a/b/c; otherwise they load 0.
REQ-017 A LATENCY+1 bit valid shift register SHALL tag accepts; fma_result is pushed into the FIFO at edge T+LATENCY+1, so out_valid is first visible after edge T+LATENCY+1 (6 cycles at default).
REQ-018 Results SHALL leave in accept order; no drop, duplication or reorder.
REQ-019 occ: +1 on accept, -1 on output handshake, unchanged when both occur in the same cycle.
REQ-020 FIFO SHALL never overflow (guaranteed by credit); push and pop in the same cycle SHALL be legal at any count, including full and empty.
REQ-021 FIFO pointers wrap modulo DEPTH; out_data = head entry, out_valid = (FIFO count != 0).
REQ-022 Sustained throughput SHALL be one result per cycle with in_valid and out_ready held high.
REQ-023 busy = (occ != 0).
REQ-024 out_data SHALL remain stable while out_valid&!out_ready.

Reset
REQ-025 On rst: occ=0, valid shift register=0, FIFO pointers/count=0, fma_a/b/c=0; therefore in_ready=1, out_valid=0, busy=0; out_data don't-care.
REQ-026 Reset mid-operation SHALL discard all in-flight and buffered results; pipeline outputs arriving after reset release SHALL be ignored.
REQ-027 FIFO storage array needs no reset.

Structure
REQ-028 Shared package fma_pkg holds FP32_W=32, FMA_LATENCY=5, binary32 field constants (sign bit 31, exponent 30:23, fraction 22:0), and the typedef fp32_t.
REQ-029 One sub-module: fma_result_fifo (synchronous, DEPTH x 32, push/pop/count); credit and valid-tag logic stay in the top.

Verification (bench pairs the block with the 5-stage clocked FMA)
REQ-030 Single op: a=0x3F800000, b=0x40000000, c=0x40400000 accepted at edge 0 -> out_data=0x40A00000 with out_valid first high after edge 6.
REQ-031 Streaming: 16 triples back-to-back, out_ready=1 -> in_ready never drops; 16 results in order, one per cycle, from edge 6.
REQ-032 Backpressure: out_ready=0, in_valid=1 -> exactly 8 accepts, in_ready=0 after the 8th, out_data stable; raise out_ready -> 8 in-order results, in_ready returns 1 the cycle after the first pop.
REQ-033 Full boundary: occ=8, pop and new in_valid in the same cycle -> no accept that cycle, accept on the next; occ sequence 8,7,8.
REQ-034 Reset mid-run: 3 in flight, 2 buffered, assert rst for one cycle -> out_valid=0, busy=0, in_ready=1 immediately; no stale results for 10 cycles; a new op 0x40000000*0x40000000+0x00000000 -> 0x40800000.

Source files
------------

// File: rtl/fma_pkg.sv
// Shared binary32 definitions and FMA pipeline constants for the FMA issue path.
package fma_pkg;

  localparam int FP32_W        = 32;
  localparam int FMA_LATENCY   = 5;

  localparam int FP32_SIGN_BIT = 31;
  localparam int FP32_EXP_MSB  = 30;
  localparam int FP32_EXP_LSB  = 23;
  localparam int FP32_FRAC_MSB = 22;
  localparam int FP32_FRAC_LSB = 0;

  typedef logic [FP32_W-1:0] fp32_t;

endpackage

// File: rtl/fma_result_fifo.sv
// Synchronous result FIFO; push and pop may coincide at any fill level.
module fma_result_fifo
  import fma_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push_i,
  input  logic [FP32_W-1:0]       push_data_i,
  input  logic                    pop_i,
  output logic [FP32_W-1:0]       head_o,
  output logic [$clog2(DEPTH):0]  count_o
);

  localparam int PTR_W = $clog2(DEPTH);

  fp32_t              mem_q [DEPTH];
  logic [PTR_W-1:0]   wptr_q;
  logic [PTR_W-1:0]   rptr_q;
  logic [PTR_W:0]     count_q;
  logic [PTR_W:0]     count_d;

  always_comb begin
    count_d = count_q;
    if (push_i && !pop_i) begin
      count_d = count_q + 1'b1;
    end else if (pop_i && !push_i) begin
      count_d = count_q - 1'b1;
    end
  end

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_i) begin
        wptr_q <= wptr_q + 1'b1;
      end
      if (pop_i) begin
        rptr_q <= rptr_q + 1'b1;
      end
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) begin
      mem_q[wptr_q] <= push_data_i;
    end
  end

  assign head_o  = mem_q[rptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/fma_issue_ctrl.sv
// Credit-based issue controller: feeds a fixed-latency FMA and buffers its results in order.
module fma_issue_ctrl
  import fma_pkg::*;
#(
  parameter int LATENCY = FMA_LATENCY,
  parameter int DEPTH   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [FP32_W-1:0] in_a,
  input  logic [FP32_W-1:0] in_b,
  input  logic [FP32_W-1:0] in_c,
  output logic [FP32_W-1:0] fma_a,
  output logic [FP32_W-1:0] fma_b,
  output logic [FP32_W-1:0] fma_c,
  input  logic [FP32_W-1:0] fma_result,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [FP32_W-1:0] out_data,
  output logic              busy
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [CNT_W-1:0] occ_q;
  logic [CNT_W-1:0] occ_d;
  logic [CNT_W-1:0] fifo_count;
  logic [LATENCY:0] vld_q;
  logic [LATENCY:0] vld_d;
  fp32_t            fma_a_q;
  fp32_t            fma_b_q;
  fp32_t            fma_c_q;
  logic             accept;
  logic             pop;
  logic             push;

  // Credit check uses only registered occupancy so a pop never feeds in_ready combinationally.
  assign in_ready  = (occ_q < CNT_W'(DEPTH));
  assign accept    = in_valid && in_ready;
  assign out_valid = (fifo_count != '0);
  assign pop       = out_valid && out_ready;
  assign push      = vld_q[LATENCY];
  assign busy      = (occ_q != '0);

  always_comb begin
    occ_d = occ_q;
    if (accept && !pop) begin
      occ_d = occ_q + 1'b1;
    end else if (pop && !accept) begin
      occ_d = occ_q - 1'b1;
    end
    vld_d = {vld_q[LATENCY-1:0], accept};
  end

  // Operands are zeroed on idle cycles so the pipeline never sees stale data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_q   <= '0;
      vld_q   <= '0;
      fma_a_q <= '0;
      fma_b_q <= '0;
      fma_c_q <= '0;
    end else begin
      occ_q   <= occ_d;
      vld_q   <= vld_d;
      fma_a_q <= accept ? in_a : '0;
      fma_b_q <= accept ? in_b : '0;
      fma_c_q <= accept ? in_c : '0;
    end
  end

  assign fma_a = fma_a_q;
  assign fma_b = fma_b_q;
  assign fma_c = fma_c_q;

  fma_result_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_data_i (fma_result),
    .pop_i       (pop),
    .head_o      (out_data),
    .count_o     (fifo_count)
  );

endmodule

// File: tb/tb_fma_issue_ctrl.sv
// Directed bench for fma_issue_ctrl paired with a 5-stage clocked FMA model.
module tb_fma_issue_ctrl;

  localparam logic [31:0] ONE = 32'h3F800000;
  localparam logic [31:0] TWO = 32'h40000000;

  logic        clk = 1'b0;
  logic        rst;
  logic        inValid;
  logic        inReady;
  logic [31:0] inA, inB, inC;
  logic [31:0] fmaA, fmaB, fmaC;
  logic [31:0] fmaResult;
  logic        outValid;
  logic        outReady;
  logic [31:0] outData;
  logic        busy;

  int testsRun  = 0;
  int failCount = 0;
  logic [31:0] expQ [$];
  logic [31:0] pipeQ [5];

  always #5 clk = ~clk;

  fma_issue_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (inValid),
    .in_ready   (inReady),
    .in_a       (inA),
    .in_b       (inB),
    .in_c       (inC),
    .fma_a      (fmaA),
    .fma_b      (fmaB),
    .fma_c      (fmaC),
    .fma_result (fmaResult),
    .out_valid  (outValid),
    .out_ready  (outReady),
    .out_data   (outData),
    .busy       (busy)
  );

  function automatic real fp32ToReal(input logic [31:0] b);
    int  e;
    real m;
    if (b[30:0] == 31'd0) return 0.0;
    e = int'(b[30:23]) - 127;
    m = 1.0 + real'(b[22:0]) / 8388608.0;
    while (e > 0) begin m = m * 2.0; e--; end
    while (e < 0) begin m = m / 2.0; e++; end
    return b[31] ? -m : m;
  endfunction

  // Exact only for values representable without rounding, which is all this bench uses.
  function automatic logic [31:0] realToFp32(input real r);
    logic s;
    real  m;
    int   e;
    int   frac;
    if (r == 0.0) return 32'h0;
    s = (r < 0.0);
    m = s ? -r : r;
    e = 0;
    while (m >= 2.0) begin m = m / 2.0; e++; end
    while (m < 1.0) begin m = m * 2.0; e--; end
    frac = $rtoi((m - 1.0) * 8388608.0);
    return {s, 8'(e + 127), 23'(frac)};
  endfunction

  function automatic logic [31:0] opA(input int i);
    return realToFp32(real'(i + 1));
  endfunction

  // Stream triples are (i+1) * 2.0 + 1.0.
  function automatic logic [31:0] expStream(input int i);
    return realToFp32(2.0 * real'(i + 1) + 1.0);
  endfunction

  always @(posedge clk) begin
    pipeQ[0] <= realToFp32(fp32ToReal(fmaA) * fp32ToReal(fmaB) + fp32ToReal(fmaC));
    for (int i = 1; i < 5; i++) pipeQ[i] <= pipeQ[i-1];
  end
  assign fmaResult = pipeQ[4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] c, input logic rdy);
    inValid  = v;
    inA      = a;
    inB      = b;
    inC      = c;
    outReady = rdy;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  // Pops n results with out_ready high, comparing each against expQ within a cycle budget.
  task automatic drainCheck(input string tag, input int n, input int maxCycles);
    int got = 0;
    for (int k = 0; k < maxCycles && got < n; k++) begin
      if (outValid) begin
        checkOutput(tag, outData, expQ.pop_front());
        got++;
      end
      tick();
    end
    if (got < n) checkOutput({tag, "_timeout"}, got, n);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int acc;
    int n;
    logic rdy;

    rst = 1'b1;
    applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_in_ready", inReady, 1);
    checkOutput("rst_out_valid", outValid, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_fma_a", fmaA, 0);
    rst = 1'b0;
    tick();

    // Single op 1*2+3 = 5
    applyStimulus(1'b1, ONE, TWO, 32'h40400000, 1'b1);
    tick();
    checkOutput("single_fma_a", fmaA, ONE);
    checkOutput("single_fma_c", fmaC, 32'h40400000);
    checkOutput("single_busy_hi", busy, 1);
    applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k == 1) checkOutput("single_fma_a_idle", fmaA, 0);
      checkOutput("single_out_valid", outValid, (k == 6) ? 1 : 0);
    end
    checkOutput("single_data", outData, 32'h40A00000);
    tick();
    checkOutput("single_busy_lo", busy, 0);

    // Streaming 16 back-to-back
    applyStimulus(1'b1, opA(0), TWO, ONE, 1'b1);
    for (int k = 0; k <= 22; k++) begin
      tick();
      if (k < 16) checkOutput("stream_in_ready", inReady, 1);
      if (k == 5) checkOutput("stream_early_valid", outValid, 0);
      if (k >= 6 && k <= 21) begin
        checkOutput("stream_valid", outValid, 1);
        checkOutput("stream_data", outData, expStream(k - 6));
      end
      if (k + 1 < 16) applyStimulus(1'b1, opA(k + 1), TWO, ONE, 1'b1);
      else            applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
    end
    checkOutput("stream_busy_lo", busy, 0);
    checkOutput("stream_valid_lo", outValid, 0);

    // Backpressure
    acc = 0;
    for (int k = 0; k < 20; k++) begin
      applyStimulus(1'b1, opA(acc), TWO, ONE, 1'b0);
      rdy = inReady;
      tick();
      if (rdy) acc++;
      if (outValid) checkOutput("bp_hold", outData, expStream(0));
    end
    checkOutput("bp_accepts", acc, 8);
    checkOutput("bp_in_ready_lo", inReady, 0);
    applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
    tick();
    checkOutput("bp_in_ready_back", inReady, 1);
    expQ.delete();
    for (int i = 1; i < 8; i++) expQ.push_back(expStream(i));
    drainCheck("bp_order", 7, 20);
    checkOutput("bp_busy_lo", busy, 0);

    // Full boundary: pop and offer in the same cycle
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b1, opA(20 + k), TWO, ONE, 1'b0);
      tick();
    end
    applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    repeat (8) tick();
    checkOutput("full_in_ready_lo", inReady, 0);
    applyStimulus(1'b1, opA(28), TWO, ONE, 1'b1);
    tick();
    checkOutput("full_after_pop", inReady, 1);
    checkOutput("full_head", outData, expStream(21));
    applyStimulus(1'b1, opA(28), TWO, ONE, 1'b0);
    tick();
    checkOutput("full_refill", inReady, 0);
    applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
    expQ.delete();
    for (int i = 21; i <= 28; i++) expQ.push_back(expStream(i));
    drainCheck("full_order", 8, 30);
    checkOutput("full_busy_lo", busy, 0);

    // Reset mid-run: 2 buffered, 3 in flight
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b1, opA(40 + k), TWO, ONE, 1'b0);
      tick();
    end
    applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    repeat (3) tick();
    checkOutput("mid_buffered", outValid, 1);
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_valid", outValid, 0);
    checkOutput("mid_rst_busy", busy, 0);
    checkOutput("mid_rst_ready", inReady, 1);
    tick();
    rst = 1'b0;
    outReady = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      checkOutput("mid_no_stale", outValid, 0);
    end
    applyStimulus(1'b1, TWO, TWO, 32'h0, 1'b1);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
    n = 0;
    while (!outValid && n < 10) begin
      tick();
      n++;
    end
    checkOutput("post_rst_latency", n, 6);
    checkOutput("post_rst_data", outData, 32'h40800000);
    tick();
    checkOutput("post_rst_busy_lo", busy, 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
